// File: rtl/i2c_slave_mem.sv
// I2C target with a 32x8 register file: pointer-addressed burst write and burst read with
// auto-increment. SCL/SDA are over-sampled on clk; SDA is driven open-drain (0 or z only).
module i2c_slave_mem #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter logic [7:0] MEM_INIT   = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,        // active-high asynchronous reset despite the name
    input  logic       scl,
    inout  wire        sda,
    output logic       wr_valid,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    input  logic [4:0] mem_rd_addr,
    output logic [7:0] mem_rd_data
);

    typedef enum logic [3:0] {
        StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
        StWdata, StWdataAck, StRdata, StRdataAck, StWaitStop
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [6:0]  tx_q, tx_d;
    logic [4:0]  ptr_q, ptr_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_d, wr_valid_d;
    logic [4:0]  wr_addr_d;
    logic [7:0]  wr_data_d;
    logic        mem_we;
    logic [7:0]  mem_q [32];

    logic scl_s1, scl_s2, scl_h, sda_s1, sda_s2, sda_h;
    logic scl_rise, scl_fall, bus_start, bus_stop;
    logic [7:0] rx_byte;

    assign sda = sda_oe_q ? 1'b0 : 1'bz;

    // Two-flop synchronizers plus a history flop for edge detection; idle bus reads high
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            {scl_s1, scl_s2, scl_h} <= 3'b111;
            {sda_s1, sda_s2, sda_h} <= 3'b111;
        end else begin
            {scl_s1, scl_s2, scl_h} <= {scl, scl_s1, scl_s2};
            {sda_s1, sda_s2, sda_h} <= {sda, sda_s1, sda_s2};
        end
    end

    assign scl_rise  = scl_s2 & ~scl_h;
    assign scl_fall  = ~scl_s2 & scl_h;
    // Qualified on the current SCL level only so a START/STOP beats a coincident SCL edge
    assign bus_start = scl_s2 & sda_h & ~sda_s2;
    assign bus_stop  = scl_s2 & ~sda_h & sda_s2;
    assign rx_byte   = {shift_q[6:0], sda_s2};

    // Protocol state register and registered outputs
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= '0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            busy      <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            busy      <= busy_d;
            wr_valid  <= wr_valid_d;
            wr_addr   <= wr_addr_d;
            wr_data   <= wr_data_d;
        end
    end

    // Next-state: bits are sampled on SCL rise, SDA only changes on SCL fall
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        ptr_d      = ptr_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr;
        wr_data_d  = wr_data;
        mem_we     = 1'b0;

        if (bus_stop) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (bus_start) begin
            state_d   = StAddr;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else begin
            unique case (state_q)
                StAddr, StPtr, StWdata: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7 && state_q == StPtr) begin
                            ptr_d = rx_byte[4:0];
                        end
                        if (bit_cnt_q == 4'd7 && state_q == StWdata) begin
                            mem_we     = 1'b1;
                            wr_valid_d = 1'b1;
                            wr_addr_d  = ptr_q;
                            wr_data_d  = rx_byte;
                            ptr_d      = ptr_q + 5'd1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (state_q == StAddr && shift_q[7:1] != SLAVE_ADDR) begin
                            state_d = StWaitStop;
                            busy_d  = 1'b0;
                        end else begin
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            state_d  = (state_q == StAddr) ? StAddrAck :
                                       (state_q == StPtr)  ? StPtrAck  : StWdataAck;
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        if (shift_q[0]) begin
                            state_d   = StRdata;
                            tx_d      = mem_q[ptr_q][6:0];
                            sda_oe_d  = ~mem_q[ptr_q][7];
                            bit_cnt_d = 4'd1;
                        end else begin
                            state_d   = StPtr;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                        end
                    end
                end
                StPtrAck, StWdataAck: begin
                    if (scl_fall) begin
                        state_d   = StWdata;
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                    end
                end
                StRdata: begin
                    // bit_cnt counts bits already placed on the bus
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            state_d   = StRdataAck;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                        end else begin
                            sda_oe_d  = ~tx_q[6];
                            tx_d      = {tx_q[5:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                StRdataAck: begin
                    // bit_cnt == 1 marks a master ACK waiting for the next fall
                    if (scl_rise && bit_cnt_q == 4'd0) begin
                        ptr_d = ptr_q + 5'd1;
                        if (sda_s2) begin
                            state_d = StWaitStop;
                        end else begin
                            bit_cnt_d = 4'd1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        state_d  = StRdata;
                        tx_d     = mem_q[ptr_q][6:0];
                        sda_oe_d = ~mem_q[ptr_q][7];
                    end
                end
                StIdle, StWaitStop: ;
                default: state_d = StIdle;
            endcase
        end
    end

    // Register file; bus write port and reset to MEM_INIT
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= MEM_INIT;
            end
        end else if (mem_we) begin
            mem_q[ptr_q] <= rx_byte;
        end
    end

    // Debug read port, one clock latency; a same-clock write returns the old byte
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            mem_rd_data <= '0;
        end else begin
            mem_rd_data <= mem_q[mem_rd_addr];
        end
    end

endmodule

// File: tb/tb_i2c_slave_mem.sv
// Bench for i2c_slave_mem: bit-banged I2C master, scoreboard queues for committed writes
// and for bytes read back over the bus.
module tb_i2c_slave_mem;

    localparam int Q = 8;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    wire        sda;
    logic       wr_valid;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic [4:0] mem_rd_addr = '0;
    logic [7:0] mem_rd_data;

    int n_checks = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int slave_low_cnt = 0;
    bit busy_seen = 1'b0;

    logic [12:0] wr_q[$];
    logic [7:0]  rd_q[$];

    assign sda = m_sda ? 1'bz : 1'b0;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_slave_mem #(.SLAVE_ADDR(7'h50), .MEM_INIT(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .scl(m_scl), .sda(sda),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Committed-write scoreboard and bus observers
    always @(negedge clk) begin
        if (wr_valid) begin
            wr_cnt++;
            if (wr_q.size() == 0) begin
                check_eq("wr_unexpected", {wr_addr, wr_data}, 13'h0);
            end else begin
                logic [12:0] e;
                e = wr_q.pop_front();
                check_eq("wr_addr", wr_addr, e[12:8]);
                check_eq("wr_data", wr_data, e[7:0]);
            end
        end
        if (m_sda && sda == 1'b0) slave_low_cnt++;
        if (busy) busy_seen = 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_q();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b1; wait_q();
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;    wait_q();
        m_scl = 1'b1; wait_q(); wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        b = sda;      wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(b);
        ack = ~b;
    endtask

    // Receive a byte and compare it against the head of the read scoreboard
    task automatic recv_byte(input logic ack_it);
        logic [7:0] d;
        logic [7:0] e;
        for (int i = 7; i >= 0; i--) recv_bit(d[i]);
        send_bit(~ack_it);
        if (rd_q.size() == 0) begin
            check_eq("rd_unexpected", d, 8'h0);
        end else begin
            e = rd_q.pop_front();
            check_eq("rd_data", d, e);
        end
    endtask

    task automatic send_chk(input string tag, input logic [7:0] d, input logic exp_ack);
        logic ack;
        send_byte(d, ack);
        check_eq(tag, ack, exp_ack);
    endtask

    task automatic send_wr(input logic [4:0] a, input logic [7:0] d);
        wr_q.push_back({a, d});
        send_chk("ack_wdata", d, 1'b1);
    endtask

    task automatic peek_chk(input string tag, input logic [4:0] a, input logic [7:0] exp);
        mem_rd_addr = a;
        @(posedge clk); #1;
        check_eq(tag, mem_rd_data, exp);
    endtask

    // Current-address read of one byte, NACKed; exposes the pointer value
    task automatic cur_read(input logic [7:0] exp);
        bus_start();
        send_chk("ack_addr_rd", 8'hA1, 1'b1);
        rd_q.push_back(exp);
        recv_byte(1'b0);
        bus_stop();
    endtask

    initial begin
        int low0;
        int wr0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst_sda", sda, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_wr_valid", wr_valid, 1'b0);
        check_eq("rst_mem_rd_data", mem_rd_data, 8'h00);
        rst_n = 1'b0;
        wait_q();

        // Seed mem[5] so the pointer left by the burst below is observable
        bus_start();
        send_chk("ack_addr_w", 8'hA0, 1'b1);
        send_chk("ack_ptr", 8'h05, 1'b1);
        send_wr(5'd5, 8'h77);
        bus_stop();

        // Write burst at 3
        bus_start();
        send_chk("ack_addr_w", 8'hA0, 1'b1);
        check_eq("busy_after_match", busy, 1'b1);
        send_chk("ack_ptr", 8'h03, 1'b1);
        send_wr(5'd3, 8'hA5);
        send_wr(5'd4, 8'h5A);
        bus_stop();
        wait_q();
        check_eq("busy_after_stop", busy, 1'b0);
        check_eq("wr_q_drained", wr_q.size(), 0);
        peek_chk("mem3", 5'd3, 8'hA5);
        peek_chk("mem4", 5'd4, 8'h5A);
        cur_read(8'h77);

        // Address mismatch
        low0 = slave_low_cnt;
        wr0 = wr_cnt;
        busy_seen = 1'b0;
        bus_start();
        send_chk("nack_addr", 8'hA2, 1'b0);
        send_chk("nack_b1", 8'h00, 1'b0);
        send_chk("nack_b2", 8'hFF, 1'b0);
        bus_stop();
        wait_q();
        check_eq("mismatch_sda_low", slave_low_cnt - low0, 0);
        check_eq("mismatch_wr", wr_cnt - wr0, 0);
        check_eq("mismatch_busy", busy_seen, 1'b0);

        // Pointer wrap on write
        bus_start();
        send_chk("ack_addr_w", 8'hA0, 1'b1);
        send_chk("ack_ptr", 8'h1F, 1'b1);
        send_wr(5'd31, 8'h33);
        send_wr(5'd0, 8'h44);
        bus_stop();
        wait_q();
        peek_chk("mem31_wrap", 5'd31, 8'h33);
        peek_chk("mem0_wrap", 5'd0, 8'h44);

        // Preload for read-with-wrap, plus mem[1] to reveal the final pointer
        bus_start();
        send_chk("ack_addr_w", 8'hA0, 1'b1);
        send_chk("ack_ptr", 8'h1F, 1'b1);
        send_wr(5'd31, 8'h11);
        send_wr(5'd0, 8'h22);
        send_wr(5'd1, 8'h99);
        bus_stop();

        // Read with wrap through a repeated START
        bus_start();
        send_chk("ack_addr_w", 8'hA0, 1'b1);
        send_chk("ack_ptr", 8'h1F, 1'b1);
        bus_start();
        send_chk("ack_addr_rd", 8'hA1, 1'b1);
        rd_q.push_back(8'h11);
        recv_byte(1'b1);
        rd_q.push_back(8'h22);
        recv_byte(1'b0);
        bus_stop();
        cur_read(8'h99);

        // STOP after four data bits
        wr0 = wr_cnt;
        bus_start();
        send_chk("ack_addr_w", 8'hA0, 1'b1);
        send_chk("ack_ptr", 8'h05, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        bus_stop();
        wait_q();
        check_eq("midstop_wr", wr_cnt - wr0, 0);
        check_eq("midstop_sda", sda, 1'b1);
        check_eq("midstop_busy", busy, 1'b0);
        peek_chk("midstop_mem5", 5'd5, 8'h77);

        // Reset while the target drives bit 7 (= 0) of mem[8]
        bus_start();
        send_chk("ack_addr_w", 8'hA0, 1'b1);
        send_chk("ack_ptr", 8'h08, 1'b1);
        send_wr(5'd8, 8'h3C);
        bus_stop();
        bus_start();
        send_chk("ack_addr_w", 8'hA0, 1'b1);
        send_chk("ack_ptr", 8'h08, 1'b1);
        bus_start();
        send_chk("ack_addr_rd", 8'hA1, 1'b1);
        @(posedge clk); #1;
        check_eq("rd_bit7_driven", sda, 1'b0);
        #3;
        rst_n = 1'b1;
        #1;
        check_eq("rst_mid_sda", sda, 1'b1);
        check_eq("rst_mid_busy", busy, 1'b0);
        m_scl = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        peek_chk("rst_mem8", 5'd8, 8'h00);
        peek_chk("rst_mem31", 5'd31, 8'h00);
        peek_chk("rst_mem5", 5'd5, 8'h00);
        check_eq("rst_wr_valid_after", wr_valid, 1'b0);
        check_eq("rd_q_drained", rd_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_slave_mem.md
Name: i2c_slave_mem

Overview:
- I2C target (slave) that answers an I2C master on the shared SCL/SDA bus.
- Holds a 32×8 register memory; supports pointer-addressed burst write and burst read with auto-increment.
- Over-samples SCL/SDA with the fabric clock; drives SDA open-drain only.
- Sits on the board side of the bus, opposite the team's I2C master/I2C_wr engine, and serves as its bench partner.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit bus address this target acknowledges.
- MEM_INIT, 8'h00, reset value of every memory byte.

Ports:
- clk  input  1  fabric clock; must be ≥16× SCL frequency.
- rst_n  input  1  one clock; reset is asynchronous and active-high (rst_n = 1 resets).
- scl  input  1  bus clock from master.
- sda  inout  1  bus data; the block drives only 1'b0 or 1'bz.
- wr_valid  output  1  one-clk pulse when a data byte is committed to memory.
- wr_addr  output  5  memory index of the committed byte.
- wr_data  output  8  committed byte.
- busy  output  1  high from address match until STOP, or until a START not addressed to us.
- mem_rd_addr  input  5  local debug read index.
- mem_rd_data  output  8  mem[mem_rd_addr], registered, 1-clk latency.

Behaviour:
- Reset values: all outputs 0, sda released (z), pointer 0, memory = MEM_INIT, state IDLE.
- Input conditioning: scl and sda each pass through a 2-flop synchronizer plus a history flop. Edges are taken from synced vs history values.
- Bus conditions:
  - START: sda falls while scl is high. Recognised in any state, including a repeated START; goes to ADDR, bit count cleared, sda released.
  - STOP: sda rises while scl is high. Any state → IDLE, sda released, busy = 0.
- Bit timing: data is sampled on the scl rising edge. The block changes sda only on the scl falling edge.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- ADDR: shifts in 8 bits, MSB first.
  - Bits [7:1] == SLAVE_ADDR: on the next scl fall drive sda = 0, enter ADDR_ACK, busy = 1.
  - Mismatch: leave sda released (NACK) and go to WAIT_STOP.
- ADDR_ACK: released on the scl fall that ends the 9th clock.
  - R/W = 0 → PTR.
  - R/W = 1 → RDATA; drive bit 7 of mem[pointer] on that same fall.
- PTR: 8 bits received; pointer = byte[4:0], bits [7:5] ignored. ACK as above, then → WDATA.
- WDATA: 8 bits received. On the 8th rising-edge sample:
  - mem[pointer] = byte.
  - wr_valid pulses for 1 clk with wr_addr = old pointer, wr_data = byte.
  - pointer = pointer + 1, mod 32 (31 → 0).
  - ACK, then return to WDATA.
- RDATA: shifts out bits 6..0 on subsequent scl falls. Releases sda on the fall after bit 0, then → RDATA_ACK.
- RDATA_ACK: samples sda on the 9th rising edge.
  - sda = 0 (master ACK): pointer += 1 (wraps); on the next fall drive bit 7 of the new mem[pointer]; → RDATA.
  - sda = 1 (NACK): pointer += 1; → WAIT_STOP, sda released.
- Read pointer increment applies to every transmitted byte, ACKed or NACKed.
- WAIT_STOP: ignores bits; only START or STOP exits.
- STOP/START mid-byte: partial byte discarded, no memory write, no wr_valid.
- A START/STOP edge in the same clk as an scl edge: START/STOP wins.
- Reset mid-transfer: immediate release of sda, all state to reset values.
- mem_rd_addr reads are independent of bus activity. A same-clk bus write to the same index returns the old value.

Test Plan:
- Write burst: START, 0xA0 (0x50 + W), 0x03, 0xA5, 0x5A, STOP → three ACKs after address. mem[3] = 0xA5, mem[4] = 0x5A. Two wr_valid pulses (addr 3 then 4). Pointer = 5.
- Address mismatch: START, 0xA2, 0x00, 0xFF, STOP → sda never driven low, no wr_valid, busy stays 0.
- Read with wrap: preload mem[31] = 0x11 and mem[0] = 0x22. START, 0xA0, 0x1F, repeated START, 0xA1; master ACKs byte 1 and NACKs byte 2; STOP → master receives 0x11 then 0x22, pointer = 1.
- Pointer wrap on write: pointer 0x1F, write 0x33, 0x44 → mem[31] = 0x33, mem[0] = 0x44, wr_addr sequence 31, 0.
- STOP mid-byte: after 4 data bits of a write byte, issue STOP → no memory change, state IDLE, sda = z.
- Reset mid-read: assert rst_n while the block drives sda = 0 → sda = z within 1 clk. Memory = MEM_INIT, busy = 0, pointer = 0.
